apb_pad_ctrl: RTL and testbench
===============================

Name: apb_pad_ctrl

Overview:
- APB3 slave that holds per-pad configuration and feeds the pad frame's 48 x 6-bit configuration input. Bit 0 of each entry drives the pad pull-enable, active low at the pad.
- Also samples the raw bootsel pad input, synchronises and debounces it, and latches a stable boot-select value for the SoC boot logic.
- Sits between the SoC peripheral APB interconnect and the pad frame.

Parameters:
- N_PADS, 48, number of pad configuration entries; must be a multiple of 4, at most 64.
- CFG_W, 6, bits per pad configuration entry; must be at most 8.
- RESET_CFG, 6'h00, reset value of every configuration entry.
- DEBOUNCE_CYCLES, 16, consecutive identical synchronised samples required to latch bootsel; minimum 1.

Ports:
- clk_i  in  1  block clock.
- rst_i  in  1  asynchronous reset, active-high.
- apb_paddr_i  in  12  byte address; bits [1:0] ignored.
- apb_psel_i  in  1  APB select.
- apb_penable_i  in  1  APB enable.
- apb_pwrite_i  in  1  1 = write.
- apb_pwdata_i  in  32  write data.
- apb_prdata_o  out  32  read data.
- apb_pready_o  out  1  transfer ready.
- apb_pslverr_o  out  1  transfer error.
- pad_cfg_o  out  N_PADS*CFG_W  packed as [N_PADS-1:0][CFG_W-1:0]; goes to the pad frame configuration input.
- bootsel_i  in  1  raw bootsel pad input, asynchronous to clk_i.
- bootsel_o  out  1  latched, debounced bootsel value.
- bootsel_valid_o  out  1  high once bootsel_o is latched.

Behaviour:
- Reset (asynchronous): every pad_cfg_o entry = RESET_CFG; lock = 0; bootsel_o = 0; bootsel_valid_o = 0; synchroniser flops = 0; debounce counter = 0; FSM = SYNC.
- APB timing: apb_pready_o is constant 1, so every access completes with zero wait states.
  - Access phase = psel & penable.
  - apb_prdata_o and apb_pslverr_o are combinational in the access phase. Both are 0 outside the access phase.
  - Writes commit at the clock edge ending the access phase; pad_cfg_o shows the new value from the next cycle.
- Register map (word index = paddr[11:2]):
  - PADCFG k, k = 0..N_PADS/4-1, offset 4k. Byte j holds pad 4k+j: bits [8j+CFG_W-1:8j] = configuration. Unused bits read 0 and ignore writes.
  - BOOTSTAT, offset N_PADS (0x30 at default). Read-only: bit0 = bootsel_o, bit1 = bootsel_valid_o. A write does nothing and sets pslverr = 1.
  - LOCK, offset N_PADS+4 (0x34 at default). Bit0 reads the lock flag. Writing 1 to bit0 sets the lock; only reset clears it. Writing 0 has no effect and no error.
  - Any other offset: read data 0, pslverr = 1, no state change.
- Lock: while lock = 1, a PADCFG write is ignored and returns pslverr = 1. PADCFG reads still return data with no error.
- Bootsel path: 2-flop synchroniser gives s; a counter feeds a 3-state FSM.
  - SYNC: wait 2 cycles after reset release for the synchroniser to fill, then go to FILTER with count = 1 and prev = s.
  - FILTER: each cycle, if s == prev then count++, else count = 1 and prev = s. When count == DEBOUNCE_CYCLES, load bootsel_o = prev, set bootsel_valid_o = 1 on the next edge, and go to DONE.
  - DONE: terminal state; bootsel_o is frozen until reset, whatever bootsel_i does.
  - Counter width = clog2(DEBOUNCE_CYCLES+1); it never wraps.
- Reset asserted mid-debounce or mid-APB-transfer: everything returns immediately to reset values; no partial write is committed.
- A write to PADCFG in the same cycle the bootsel FSM latches: the two are independent and both take effect.

Test Plan:
- Reset release with no APB traffic -> all 48 pad_cfg_o entries = 6'h00; reading 0x00..0x2C returns 0 with pslverr = 0.
- Write 0x3F2A_1501 to 0x08 -> from the next cycle pad8 = 0x01, pad9 = 0x15, pad10 = 0x2A, pad11 = 0x3F. Readback = 0x3F2A_1501. Write 0xFFFF_FFFF to 0x08 -> readback 0x3F3F_3F3F.
- Write 1 to 0x34, then write 0x0000_0001 to 0x00 -> pslverr = 1 and pad0 unchanged. Read 0x34 = 1. After reset, lock = 0.
- Access 0x38 and 0x100 -> pslverr = 1 and read data 0. Write 0x30 -> pslverr = 1 and BOOTSTAT unchanged.
- bootsel_i held at 1 from reset release -> bootsel_valid_o rises exactly 2+16 cycles after reset release (within ±1 per synchroniser alignment) with bootsel_o = 1. Toggling bootsel_i afterwards leaves bootsel_o = 1.
- bootsel_i glitches 1 for 5 cycles, then holds 0 -> no latch during the glitch; bootsel_o = 0 latched 16 cycles after the glitch is seen. Asserting rst_i mid-count clears bootsel_valid_o and the count restarts.

Source files
------------

// File: rtl/apb_pad_ctrl.sv
// APB3 pad configuration register file plus a debounced, latch-once bootsel sampler.
// Pad entries feed the pad frame directly; bootsel is frozen after the first stable run.
module apb_pad_ctrl #(
  parameter int unsigned N_PADS          = 48,
  parameter int unsigned CFG_W           = 6,
  parameter logic [CFG_W-1:0] RESET_CFG  = '0,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [11:0]                   apb_paddr_i,
  input  logic                          apb_psel_i,
  input  logic                          apb_penable_i,
  input  logic                          apb_pwrite_i,
  input  logic [31:0]                   apb_pwdata_i,
  output logic [31:0]                   apb_prdata_o,
  output logic                          apb_pready_o,
  output logic                          apb_pslverr_o,
  output logic [N_PADS-1:0][CFG_W-1:0]  pad_cfg_o,
  input  logic                          bootsel_i,
  output logic                          bootsel_o,
  output logic                          bootsel_valid_o
);

  // state     | meaning
  // ST_SYNC   | synchroniser filling after reset release
  // ST_FILTER | counting consecutive identical samples
  // ST_DONE   | bootsel latched, frozen until reset
  typedef enum logic [1:0] {ST_SYNC, ST_FILTER, ST_DONE} bs_state_e;

  localparam int unsigned N_WORDS = N_PADS / 4;
  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [9:0]  BOOTSTAT_IDX = 10'(N_WORDS);
  localparam logic [9:0]  LOCK_IDX     = 10'(N_WORDS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

  logic [N_PADS-1:0][CFG_W-1:0] cfg_q, cfg_d;
  logic                         lock_q, lock_d;
  logic [31:0]                  rdata;
  logic                         slverr;
  logic                         access;
  logic [9:0]                   word_idx;

  logic                         sync1_q, sync2_q;
  logic                         wait_q, wait_d;
  logic                         prev_q, prev_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  bs_state_e                    state_q, state_d;
  logic                         bootsel_q, bootsel_d;
  logic                         valid_q, valid_d;

  logic                         unused_bits;

  assign access   = apb_psel_i & apb_penable_i;
  assign word_idx = apb_paddr_i[11:2];
  assign unused_bits = ^{apb_paddr_i[1:0], apb_pwdata_i};

  always_comb begin
    rdata  = '0;
    slverr = 1'b0;
    cfg_d  = cfg_q;
    lock_d = lock_q;
    if (access) begin
      if (word_idx < 10'(N_WORDS)) begin
        for (int j = 0; j < 4; j++) begin
          rdata[8*j +: CFG_W] = cfg_q[{word_idx[3:0], 2'(j)}];
          if (apb_pwrite_i && !lock_q)
            cfg_d[{word_idx[3:0], 2'(j)}] = apb_pwdata_i[8*j +: CFG_W];
        end
        slverr = apb_pwrite_i & lock_q;
      end else if (word_idx == BOOTSTAT_IDX) begin
        rdata[1:0] = {valid_q, bootsel_q};
        slverr     = apb_pwrite_i;
      end else if (word_idx == LOCK_IDX) begin
        rdata[0] = lock_q;
        if (apb_pwrite_i && apb_pwdata_i[0])
          lock_d = 1'b1;
      end else begin
        slverr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_q  <= {N_PADS{RESET_CFG}};
      lock_q <= 1'b0;
    end else begin
      cfg_q  <= cfg_d;
      lock_q <= lock_d;
    end
  end

  assign apb_prdata_o  = rdata;
  assign apb_pslverr_o = slverr;
  assign apb_pready_o  = 1'b1;
  assign pad_cfg_o     = cfg_q;

  // Count saturates at DEBOUNCE_CYCLES because FILTER leaves on reaching it.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    prev_d    = prev_q;
    cnt_d     = cnt_q;
    bootsel_d = bootsel_q;
    valid_d   = valid_q;
    case (state_q)
      ST_SYNC: begin
        if (wait_q) begin
          state_d = ST_FILTER;
          cnt_d   = CNT_ONE;
          prev_d  = sync2_q;
        end else begin
          wait_d = 1'b1;
        end
      end
      ST_FILTER: begin
        if (cnt_q == CNT_DONE) begin
          bootsel_d = prev_q;
          valid_d   = 1'b1;
          state_d   = ST_DONE;
        end else if (sync2_q == prev_q) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d  = CNT_ONE;
          prev_d = sync2_q;
        end
      end
      ST_DONE: ;
      default: state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      wait_q    <= 1'b0;
      prev_q    <= 1'b0;
      cnt_q     <= '0;
      state_q   <= ST_SYNC;
      bootsel_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      sync1_q   <= bootsel_i;
      sync2_q   <= sync1_q;
      wait_q    <= wait_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      bootsel_q <= bootsel_d;
      valid_q   <= valid_d;
    end
  end

  assign bootsel_o       = bootsel_q;
  assign bootsel_valid_o = valid_q;

endmodule

// File: tb/tb_apb_pad_ctrl.sv
// Scoreboard bench for apb_pad_ctrl: random APB traffic against a register-map model,
// plus directed bootsel debounce timing checks.
module tb_apb_pad_ctrl;
  localparam int N_PADS = 48;
  localparam int CFG_W  = 6;
  localparam int DEB    = 16;
  localparam int NW     = N_PADS / 4;
  localparam int PW     = N_PADS * CFG_W;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [11:0] apb_paddr_i = '0;
  logic        apb_psel_i = 1'b0, apb_penable_i = 1'b0, apb_pwrite_i = 1'b0;
  logic [31:0] apb_pwdata_i = '0;
  logic [31:0] apb_prdata_o;
  logic        apb_pready_o, apb_pslverr_o;
  logic [N_PADS-1:0][CFG_W-1:0] pad_cfg_o;
  logic        bootsel_i = 1'b1;
  logic        bootsel_o, bootsel_valid_o;

  apb_pad_ctrl #(.N_PADS(N_PADS), .CFG_W(CFG_W), .RESET_CFG(6'h00), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .apb_paddr_i(apb_paddr_i), .apb_psel_i(apb_psel_i), .apb_penable_i(apb_penable_i),
    .apb_pwrite_i(apb_pwrite_i), .apb_pwdata_i(apb_pwdata_i), .apb_prdata_o(apb_prdata_o),
    .apb_pready_o(apb_pready_o), .apb_pslverr_o(apb_pslverr_o), .pad_cfg_o(pad_cfg_o),
    .bootsel_i(bootsel_i), .bootsel_o(bootsel_o), .bootsel_valid_o(bootsel_valid_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0]   rdata;
    logic          slverr;
    bit            chk_rd;
    logic [PW-1:0] pads;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [CFG_W-1:0] m_cfg [N_PADS];
  bit m_lock, m_bs, m_bsv;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int val, input int lo, input int hi);
    n_vec++;
    if (val < lo || val > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
    end
  endtask

  function automatic logic [PW-1:0] model_pads();
    logic [PW-1:0] r = '0;
    for (int i = 0; i < N_PADS; i++) r[i*CFG_W +: CFG_W] = m_cfg[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_PADS; i++) m_cfg[i] = '0;
    m_lock = 0; m_bs = 0; m_bsv = 0;
  endtask

  // Register-map behaviour expressed per access in plain arithmetic.
  task automatic apb(input logic [11:0] a, input bit wr, input logic [31:0] wd);
    exp_t e;
    int   w;
    @(negedge clk_i);
    apb_psel_i = 1; apb_penable_i = 0; apb_paddr_i = a; apb_pwrite_i = wr; apb_pwdata_i = wd;
    @(negedge clk_i);
    apb_penable_i = 1;
    w = int'(a) / 4;
    e.rdata = '0; e.slverr = 0; e.chk_rd = !wr; e.pads = model_pads();
    if (w < NW) begin
      for (int j = 0; j < 4; j++) e.rdata[8*j +: 8] = 8'(m_cfg[4*w+j]);
      e.slverr = wr && m_lock;
      if (wr && !m_lock)
        for (int j = 0; j < 4; j++) m_cfg[4*w+j] = wd[8*j +: CFG_W];
    end else if (w == NW) begin
      e.rdata = 32'(m_bs) + 32'(m_bsv) * 2;
      e.slverr = wr;
    end else if (w == NW + 1) begin
      e.rdata = 32'(m_lock);
      if (wr && wd[0]) m_lock = 1;
    end else begin
      e.slverr = 1;
    end
    sb.push_back(e);
    @(negedge clk_i);
    apb_psel_i = 0; apb_penable_i = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      #2;
      if (apb_psel_i && apb_penable_i) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("pslverr", PW'(apb_pslverr_o), PW'(e.slverr));
          chk("pready", PW'(apb_pready_o), PW'(1));
          if (e.chk_rd) chk("prdata", PW'(apb_prdata_o), PW'(e.rdata));
          chk("pad_cfg", pad_cfg_o, e.pads);
        end
      end
    end
  end

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bootsel_valid_o && cyc < 40) begin
      @(posedge clk_i);
      #1;
      cyc++;
    end
  endtask

  initial begin : watchdog
    #150000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int cyc;
    int r, w;
    logic [11:0] a;
    model_reset();
    bootsel_i = 1;
    rst_i = 1;
    repeat (2) @(negedge clk_i);
    rst_i = 0;
    chk("reset_pads", pad_cfg_o, '0);
    chk("reset_valid", PW'(bootsel_valid_o), 0);
    chk("reset_bootsel", PW'(bootsel_o), 0);
    fork
      wait_valid(cyc);
      for (int k = 0; k < NW; k++) apb(12'(4*k), 0, 0);
    join
    chk_range("latency_hold1", cyc, 2 + DEB - 1, 2 + DEB + 2);
    chk("latched_1", PW'(bootsel_o), 1);
    m_bs = 1; m_bsv = 1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_i);
      bootsel_i = 1'($urandom);
    end
    repeat (4) @(negedge clk_i);
    chk("frozen_bootsel", PW'(bootsel_o), 1);
    chk("frozen_valid", PW'(bootsel_valid_o), 1);

    apb(12'h008, 1, 32'h3F2A_1501);
    chk("pad8", PW'(pad_cfg_o[8]), PW'(6'h01));
    chk("pad9", PW'(pad_cfg_o[9]), PW'(6'h15));
    chk("pad10", PW'(pad_cfg_o[10]), PW'(6'h2A));
    chk("pad11", PW'(pad_cfg_o[11]), PW'(6'h3F));
    apb(12'h008, 0, 0);
    apb(12'h008, 1, 32'hFFFF_FFFF);
    apb(12'h008, 0, 0);
    apb(12'h034, 1, 32'h1);
    apb(12'h000, 1, 32'h1);
    chk("pad0_locked", PW'(pad_cfg_o[0]), 0);
    apb(12'h000, 0, 0);
    apb(12'h034, 0, 0);
    apb(12'h034, 1, 32'h0);
    apb(12'h038, 0, 0);
    apb(12'h038, 1, 32'h5A5A_5A5A);
    apb(12'h100, 0, 0);
    apb(12'h100, 1, 32'h1234_5678);
    apb(12'h030, 1, 32'hFFFF_FFFF);
    apb(12'h030, 0, 0);

    @(negedge clk_i);
    rst_i = 1; bootsel_i = 0;
    model_reset();
    #1;
    chk("rst_pads", pad_cfg_o, '0);
    chk("rst_valid", PW'(bootsel_valid_o), 0);
    chk("rst_bootsel", PW'(bootsel_o), 0);
    @(negedge clk_i);
    rst_i = 0;
    repeat (6) @(negedge clk_i);
    bootsel_i = 1;
    repeat (5) @(negedge clk_i);
    bootsel_i = 0;
    chk("glitch_no_latch", PW'(bootsel_valid_o), 0);
    wait_valid(cyc);
    chk_range("latency_after_glitch", cyc, 2 + DEB - 2, 2 + DEB + 2);
    chk("latched_0", PW'(bootsel_o), 0);

    @(negedge clk_i);
    bootsel_i = 1; rst_i = 1;
    #1;
    chk("rst_clears_valid", PW'(bootsel_valid_o), 0);
    @(negedge clk_i);
    rst_i = 0;
    repeat (10) @(negedge clk_i);
    chk("mid_count_valid", PW'(bootsel_valid_o), 0);
    rst_i = 1;
    @(negedge clk_i);
    rst_i = 0;
    wait_valid(cyc);
    chk_range("latency_restart", cyc, 2 + DEB - 1, 2 + DEB + 2);
    chk("latched_restart", PW'(bootsel_o), 1);
    model_reset();
    m_bs = 1; m_bsv = 1;

    apb(12'h034, 0, 0);
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      w = $urandom_range(0, NW - 1);
      else if (r < 80) w = NW;
      else if (r < 81) w = NW + 1;
      else             w = $urandom_range(0, 1023);
      a = {10'(w), 2'($urandom)};
      apb(a, 1'($urandom), $urandom);
    end
    repeat (3) @(negedge clk_i);
    chk("sb_drained", PW'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
